// File: rtl/rv_core_mc_if.sv
// rv_core_mc_if: memory-side bundle of the multi-cycle core.
//   imem_addr  core -> ROM  fetch address (byte address, equals pc)
//   imem_rdata ROM -> core  instruction, valid the cycle after imem_addr
//   dmem_addr  core -> bus  load/store byte address
//   dmem_wdata core -> bus  store data
//   dmem_we    core -> bus  store request, held until dmem_ready
//   dmem_re    core -> bus  load request, held until dmem_ready
//   dmem_rdata bus -> core  load data, valid while dmem_ready=1
//   dmem_ready bus -> core  accepts the pending request this cycle
// Modports: master (core side), slave (memory/bus side).
interface rv_core_mc_if #(
    parameter int PC_W    = 8,
    parameter int DADDR_W = 8
);
    logic [PC_W-1:0]    imem_addr;
    logic [31:0]        imem_rdata;
    logic [DADDR_W-1:0] dmem_addr;
    logic [31:0]        dmem_wdata;
    logic               dmem_we;
    logic               dmem_re;
    logic [31:0]        dmem_rdata;
    logic               dmem_ready;

    modport master (
        output imem_addr, dmem_addr, dmem_wdata, dmem_we, dmem_re,
        input  imem_rdata, dmem_rdata, dmem_ready
    );

    modport slave (
        input  imem_addr, dmem_addr, dmem_wdata, dmem_we, dmem_re,
        output imem_rdata, dmem_rdata, dmem_ready
    );
endinterface

// File: rtl/rv_core_mc.sv
// rv_core_mc: multi-cycle RV32I-subset core (R/I ALU ops, lw, sw, beq, bne, jal).
// Sequenced FETCH -> DECODE -> EXEC -> (MEM) -> (WB), with HALT as a terminal state.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   bus          rv_core_mc_if master: instruction ROM and handshaked data port
//   pc_out       current pc
//   retire       one-cycle pulse on the cycle whose closing edge commits the pc update
//   instret      retired-instruction count, saturating
//   halted       core is stopped (sticky until reset)
//   illegal      the halt came from an unsupported opcode (sticky until reset)
module rv_core_mc #(
    parameter int PC_W     = 8,
    parameter int DADDR_W  = 8,
    parameter int NREG     = 32,
    parameter int RESET_PC = 0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    rv_core_mc_if.master     bus,
    output logic [PC_W-1:0]  pc_out,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             halted,
    output logic             illegal
);
    localparam int RW = $clog2(NREG);
    // pc updates always land word-aligned
    localparam logic [PC_W-1:0] PC_MASK = ~PC_W'(3);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    state_t           state_reg, state_next;
    logic [PC_W-1:0]  pc_reg, pc_next;
    logic             illegal_reg, illegal_next;
    logic [CNT_W-1:0] instret_reg;
    logic [31:0]      ir_reg, a_reg, b_reg, alu_reg, mdr_reg;
    logic [31:0]      rf_reg [NREG];

    logic             rf_we;
    logic [31:0]      wb_data;
    logic             dmem_we_c, dmem_re_c;

    // ---------------- decode of the latched instruction ----------------
    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic [RW-1:0] rd_idx, rs1_idx, rs2_idx;
    logic          is_r, is_i, is_lw, is_sw, is_br, is_jal;
    logic [31:0]   imm_i, imm_s, imm_b, imm_j;

    assign opcode  = ir_reg[6:0];
    assign funct3  = ir_reg[14:12];
    assign rd_idx  = ir_reg[7 +: RW];
    // source registers are read straight from the ROM word while in DECODE
    assign rs1_idx = bus.imem_rdata[15 +: RW];
    assign rs2_idx = bus.imem_rdata[20 +: RW];

    assign is_r   = (opcode == 7'b0110011);
    assign is_i   = (opcode == 7'b0010011);
    assign is_lw  = (opcode == 7'b0000011);
    assign is_sw  = (opcode == 7'b0100011);
    assign is_br  = (opcode == 7'b1100011);
    assign is_jal = (opcode == 7'b1101111);

    assign imm_i = {{20{ir_reg[31]}}, ir_reg[31:20]};
    assign imm_s = {{20{ir_reg[31]}}, ir_reg[31:25], ir_reg[11:7]};
    assign imm_b = {{19{ir_reg[31]}}, ir_reg[31], ir_reg[7], ir_reg[30:25], ir_reg[11:8], 1'b0};
    assign imm_j = {{11{ir_reg[31]}}, ir_reg[31], ir_reg[19:12], ir_reg[20], ir_reg[30:21], 1'b0};

    // ---------------- ALU ----------------
    logic [31:0] alu_b, alu_y;
    logic [2:0]  alu_f3;
    logic        alu_alt;
    logic [4:0]  shamt;

    always_comb begin
        alu_b   = is_r ? b_reg : (is_sw ? imm_s : imm_i);
        // address generation for lw/sw is always an add
        alu_f3  = (is_lw || is_sw) ? 3'b000 : funct3;
        // bit 30 selects sub/sra; for I-type it only means something on shifts (srai)
        alu_alt = ir_reg[30] && (is_r || (is_i && funct3 == 3'b101));
        shamt   = alu_b[4:0];
        case (alu_f3)
            3'b000:  alu_y = alu_alt ? (a_reg - alu_b) : (a_reg + alu_b);
            3'b001:  alu_y = a_reg << shamt;
            3'b010:  alu_y = {31'b0, ($signed(a_reg) < $signed(alu_b))};
            3'b011:  alu_y = {31'b0, (a_reg < alu_b)};
            3'b100:  alu_y = a_reg ^ alu_b;
            3'b101:  alu_y = alu_alt ? 32'($signed(a_reg) >>> shamt) : (a_reg >> shamt);
            3'b110:  alu_y = a_reg | alu_b;
            default: alu_y = a_reg & alu_b;
        endcase
    end

    // ---------------- pc arithmetic (32-bit, truncated to PC_W) ----------------
    logic [PC_W-1:0] pc_plus4, pc_br, pc_jal;
    logic            br_taken;

    assign pc_plus4 = PC_W'(32'(pc_reg) + 32'd4);
    assign pc_br    = PC_W'(32'(pc_reg) + imm_b);
    assign pc_jal   = PC_W'(32'(pc_reg) + imm_j);
    // funct3[0] distinguishes bne from beq
    assign br_taken = funct3[0] ? (a_reg != b_reg) : (a_reg == b_reg);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= S_FETCH;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        illegal_next = illegal_reg;
        retire       = 1'b0;
        rf_we        = 1'b0;
        wb_data      = alu_reg;
        dmem_we_c    = 1'b0;
        dmem_re_c    = 1'b0;
        case (state_reg)
            S_FETCH: state_next = S_DECODE;
            S_DECODE: begin
                if (bus.imem_rdata == 32'd0) begin
                    state_next = S_HALT;
                end else if (!(bus.imem_rdata[6:0] inside {7'b0110011, 7'b0010011, 7'b0000011,
                                                           7'b0100011, 7'b1100011, 7'b1101111})) begin
                    state_next   = S_HALT;
                    illegal_next = 1'b1;
                end else begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_br) begin
                    pc_next    = (br_taken ? pc_br : pc_plus4) & PC_MASK;
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end else if (is_lw || is_sw) begin
                    state_next = S_MEM;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MEM: begin
                dmem_re_c = is_lw;
                dmem_we_c = is_sw;
                if (bus.dmem_ready) begin
                    if (is_sw) begin
                        pc_next    = pc_plus4 & PC_MASK;
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we      = (rd_idx != '0);
                wb_data    = is_lw ? mdr_reg : (is_jal ? 32'(pc_plus4 & PC_MASK) : alu_reg);
                pc_next    = (is_jal ? pc_jal : pc_plus4) & PC_MASK;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_HALT: state_next = S_HALT;
            default: state_next = S_FETCH;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg      <= PC_W'(RESET_PC);
            illegal_reg <= 1'b0;
            instret_reg <= '0;
            ir_reg      <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            alu_reg     <= '0;
            mdr_reg     <= '0;
        end else begin
            pc_reg      <= pc_next;
            illegal_reg <= illegal_next;
            if (state_reg == S_DECODE) begin
                ir_reg <= bus.imem_rdata;
                a_reg  <= rf_reg[rs1_idx];
                b_reg  <= rf_reg[rs2_idx];
            end
            if (state_reg == S_EXEC) alu_reg <= alu_y;
            if (state_reg == S_MEM && bus.dmem_ready) mdr_reg <= bus.dmem_rdata;
            if (retire && instret_reg != '1) instret_reg <= instret_reg + 1'b1;
        end
    end

    // Register file is flop-based so every entry clears on reset.
    // Entry 0 is never written (rf_we excludes rd=0), so x0 always reads 0.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_rf
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                             rf_reg[gi] <= '0;
            else if (rf_we && rd_idx == RW'(gi))    rf_reg[gi] <= wb_data;
        end
    end

    // ---------------- outputs ----------------
    assign bus.imem_addr  = pc_reg;
    assign bus.dmem_addr  = alu_reg[DADDR_W-1:0];
    assign bus.dmem_wdata = b_reg;
    assign bus.dmem_we    = dmem_we_c;
    assign bus.dmem_re    = dmem_re_c;
    assign pc_out         = pc_reg;
    assign instret        = instret_reg;
    assign halted         = (state_reg == S_HALT);
    assign illegal        = illegal_reg;
endmodule

// File: tb/tb_rv_core_mc.sv
module tb_rv_core_mc;
    localparam logic [6:0] OPI = 7'b0010011;
    localparam logic [6:0] OPL = 7'b0000011;

    logic        clk;
    logic        rst_n;
    logic [7:0]  pc_out;
    logic        retire;
    logic [15:0] instret;
    logic        halted;
    logic        illegal;

    rv_core_mc_if #(.PC_W(8), .DADDR_W(8)) bus ();

    rv_core_mc #(.PC_W(8), .DADDR_W(8), .NREG(32), .RESET_PC(0), .CNT_W(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .pc_out  (pc_out),
        .retire  (retire),
        .instret (instret),
        .halted  (halted),
        .illegal (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // instruction ROM (1-cycle synchronous read) and data RAM with programmable wait states
    logic [31:0] rom [64];
    logic [31:0] ram [64];
    int          ready_delay;
    int          wait_cnt;

    always @(posedge clk) bus.imem_rdata <= rom[bus.imem_addr[7:2]];
    assign bus.dmem_ready = (bus.dmem_we || bus.dmem_re) && (wait_cnt >= ready_delay);
    assign bus.dmem_rdata = ram[bus.dmem_addr[7:2]];
    always @(posedge clk) begin
        if ((bus.dmem_we || bus.dmem_re) && !bus.dmem_ready) wait_cnt <= wait_cnt + 1;
        else                                                 wait_cnt <= 0;
        if (bus.dmem_we && bus.dmem_ready) ram[bus.dmem_addr[7:2]] <= bus.dmem_wdata;
    end

    int          n_cmp = 0;
    int          n_fail = 0;
    int          we_seen;
    logic [7:0]  seen_addr;
    logic [31:0] seen_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                          input logic [2:0] f3, input int rd);
        return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input logic [2:0] f3,
                                          input int rd, input logic [6:0] op);
        return {12'(imm), 5'(rs1), f3, 5'(rd), op};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
        logic [11:0] i;
        i = 12'(imm);
        return {i[11:5], 5'(rs2), 5'(rs1), 3'b010, i[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input logic [2:0] f3);
        logic [12:0] i;
        i = 13'(imm);
        return {i[12], i[10:5], 5'(rs2), 5'(rs1), f3, i[4:1], i[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input int rd);
        logic [20:0] i;
        i = 21'(imm);
        return {i[20], i[10:1], i[11], i[19:12], 5'(rd), 7'b1101111};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) begin
            rom[i] = 32'd0;
            ram[i] = 32'd0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Runs one instruction from its FETCH cycle; returns its length in clocks and
    // leaves time at #1 after the edge that committed it.
    task automatic run_instr(output int lat);
        lat = 0;
        we_seen = 0;
        do begin
            @(negedge clk);
            lat++;
            chk("we_re_exclusive", {31'b0, bus.dmem_we & bus.dmem_re}, 32'd0);
            if (bus.dmem_we) begin
                we_seen++;
                seen_addr  = bus.dmem_addr;
                seen_wdata = bus.dmem_wdata;
            end
        end while (!retire && lat < 60);
        chk("retire_seen", {31'b0, retire}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int total;
        int bad_addr;
        int mem_act;
        logic [31:0] exp_rf [16];

        rst_n = 1'b0;
        ready_delay = 0;

        // ---- Test 1: addi/addi/add then halt ----
        clear_mem();
        rom[0] = enc_i(5, 0, 3'b000, 1, OPI);
        rom[1] = enc_i(-3, 1, 3'b000, 2, OPI);
        rom[2] = enc_r(7'h00, 2, 1, 3'b000, 3);
        do_reset();
        chk("rst_pc", 32'(pc_out), 32'h0);
        chk("rst_imem_addr", 32'(bus.imem_addr), 32'h0);
        chk("rst_instret", 32'(instret), 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        chk("rst_illegal", {31'b0, illegal}, 32'd0);
        chk("rst_retire", {31'b0, retire}, 32'd0);
        chk("rst_dmem_we", {31'b0, bus.dmem_we}, 32'd0);
        chk("rst_dmem_re", {31'b0, bus.dmem_re}, 32'd0);
        total = 0;
        for (int k = 0; k < 3; k++) begin
            run_instr(lat);
            chk("t1_lat", lat, 32'd4);
            total += lat;
        end
        chk("t1_total_cycles", total, 32'd12);
        chk("t1_retire_one_cycle", {31'b0, retire}, 32'd0);
        chk("t1_x1", dut.rf_reg[1], 32'd5);
        chk("t1_x2", dut.rf_reg[2], 32'd2);
        chk("t1_x3", dut.rf_reg[3], 32'd7);
        repeat (3) @(negedge clk);
        chk("t1_halted", {31'b0, halted}, 32'd1);
        chk("t1_illegal", {31'b0, illegal}, 32'd0);
        chk("t1_instret", 32'(instret), 32'd3);
        chk("t1_pc", 32'(pc_out), 32'h0C);

        // ---- Test 2: ALU coverage ----
        clear_mem();
        rom[0]  = enc_i(-8, 0, 3'b000, 1, OPI);
        rom[1]  = enc_i(3, 0, 3'b000, 2, OPI);
        rom[2]  = enc_r(7'h20, 2, 1, 3'b000, 3);   // sub
        rom[3]  = enc_r(7'h20, 2, 1, 3'b101, 4);   // sra
        rom[4]  = enc_r(7'h00, 2, 1, 3'b101, 5);   // srl
        rom[5]  = enc_r(7'h00, 2, 1, 3'b010, 6);   // slt
        rom[6]  = enc_r(7'h00, 2, 1, 3'b100, 7);   // xor
        rom[7]  = enc_r(7'h00, 2, 1, 3'b111, 8);   // and
        rom[8]  = enc_r(7'h00, 2, 1, 3'b110, 9);   // or
        rom[9]  = enc_r(7'h00, 2, 2, 3'b001, 10);  // sll x10,x2,x2
        rom[10] = enc_i(-9, 1, 3'b010, 11, OPI);   // slti x11,x1,-9
        rom[11] = enc_i(12'h402, 1, 3'b101, 12, OPI); // srai x12,x1,2
        rom[12] = enc_i(12'h400, 2, 3'b000, 13, OPI); // addi x13,x2,0x400
        exp_rf[3]  = 32'hFFFF_FFF5;
        exp_rf[4]  = 32'hFFFF_FFFF;
        exp_rf[5]  = 32'h1FFF_FFFF;
        exp_rf[6]  = 32'h0000_0001;
        exp_rf[7]  = 32'hFFFF_FFFB;
        exp_rf[8]  = 32'h0000_0000;
        exp_rf[9]  = 32'hFFFF_FFFB;
        exp_rf[10] = 32'h0000_0018;
        exp_rf[11] = 32'h0000_0000;
        exp_rf[12] = 32'hFFFF_FFFE;
        exp_rf[13] = 32'h0000_0403;
        do_reset();
        chk("t2_rf_cleared", dut.rf_reg[3], 32'd0);
        for (int k = 0; k < 13; k++) run_instr(lat);
        for (int k = 3; k < 14; k++) chk($sformatf("t2_x%0d", k), dut.rf_reg[k], exp_rf[k]);

        // ---- Test 3: branches and jal ----
        clear_mem();
        rom[0] = enc_i(4, 0, 3'b000, 1, OPI);
        rom[1] = enc_i(4, 0, 3'b000, 2, OPI);
        rom[2] = enc_i(0, 0, 3'b000, 0, OPI);
        rom[3] = enc_i(0, 0, 3'b000, 0, OPI);
        rom[4] = enc_b(8, 2, 1, 3'b000);   // 0x10 beq x1,x2,+8
        rom[6] = enc_b(8, 2, 1, 3'b001);   // 0x18 bne x1,x2,+8
        rom[7] = enc_j(4, 0);              // 0x1C jal x0,+4
        rom[8] = enc_j(-16, 1);            // 0x20 jal x1,-16
        do_reset();
        for (int k = 0; k < 4; k++) run_instr(lat);
        chk("t3_pc_at_beq", 32'(pc_out), 32'h10);
        run_instr(lat);
        chk("t3_beq_lat", lat, 32'd3);
        chk("t3_beq_taken_pc", 32'(pc_out), 32'h18);
        run_instr(lat);
        chk("t3_bne_lat", lat, 32'd3);
        chk("t3_bne_fall_pc", 32'(pc_out), 32'h1C);
        run_instr(lat);
        chk("t3_jal_x0_lat", lat, 32'd4);
        chk("t3_jal_x0_pc", 32'(pc_out), 32'h20);
        chk("t3_x0_zero", dut.rf_reg[0], 32'd0);
        run_instr(lat);
        chk("t3_jal_lat", lat, 32'd4);
        chk("t3_jal_pc", 32'(pc_out), 32'h10);
        chk("t3_jal_link", dut.rf_reg[1], 32'h24);
        run_instr(lat);
        chk("t3_beq_ntaken_pc", 32'(pc_out), 32'h14);
        repeat (3) @(negedge clk);
        chk("t3_halted", {31'b0, halted}, 32'd1);
        chk("t3_instret", 32'(instret), 32'd9);

        // ---- Test 4: sw with wait states, then lw ----
        clear_mem();
        rom[0] = enc_i(8, 0, 3'b000, 1, OPI);
        rom[1] = enc_i(12'h37A, 0, 3'b000, 2, OPI);
        rom[2] = enc_i(11, 2, 3'b001, 2, OPI);
        rom[3] = enc_i(12'h5B7, 2, 3'b110, 2, OPI);
        rom[4] = enc_i(11, 2, 3'b001, 2, OPI);
        rom[5] = enc_i(12'h6EF, 2, 3'b110, 2, OPI);
        rom[6] = enc_s(4, 2, 1);                    // sw x2,4(x1)
        rom[7] = enc_i(4, 1, 3'b010, 5, OPL);       // lw x5,4(x1)
        do_reset();
        for (int k = 0; k < 6; k++) run_instr(lat);
        chk("t4_x2_built", dut.rf_reg[2], 32'hDEAD_BEEF);
        ready_delay = 3;
        run_instr(lat);
        chk("t4_sw_lat", lat, 32'd7);
        chk("t4_sw_we_cycles", we_seen, 32'd4);
        chk("t4_sw_addr", 32'(seen_addr), 32'h0C);
        chk("t4_sw_wdata", seen_wdata, 32'hDEAD_BEEF);
        chk("t4_ram_written", ram[3], 32'hDEAD_BEEF);
        chk("t4_sw_pc", 32'(pc_out), 32'h1C);
        ready_delay = 0;
        run_instr(lat);
        chk("t4_lw_lat", lat, 32'd5);
        chk("t4_lw_x5", dut.rf_reg[5], 32'hDEAD_BEEF);
        chk("t4_lw_pc", 32'(pc_out), 32'h20);

        // ---- Test 5: illegal opcode ----
        clear_mem();
        rom[0] = enc_i(0, 0, 3'b000, 0, OPI);
        rom[1] = enc_i(0, 0, 3'b000, 0, OPI);
        rom[2] = 32'h0000_007F;
        do_reset();
        run_instr(lat);
        run_instr(lat);
        bad_addr = 0;
        mem_act  = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.imem_addr != 8'h08) bad_addr++;
            if (bus.dmem_we || bus.dmem_re) mem_act++;
        end
        chk("t5_halted", {31'b0, halted}, 32'd1);
        chk("t5_illegal", {31'b0, illegal}, 32'd1);
        chk("t5_pc", 32'(pc_out), 32'h08);
        chk("t5_imem_addr_frozen", bad_addr, 32'd0);
        chk("t5_no_dmem", mem_act, 32'd0);
        chk("t5_instret", 32'(instret), 32'd2);

        // ---- Test 6: reset during a stalled store ----
        clear_mem();
        rom[0] = enc_i(8, 0, 3'b000, 1, OPI);
        rom[1] = enc_i(12'h055, 0, 3'b000, 2, OPI);
        rom[2] = enc_s(0, 2, 1);
        do_reset();
        run_instr(lat);
        run_instr(lat);
        ready_delay = 1000;
        for (int k = 0; k < 10 && !bus.dmem_we; k++) @(negedge clk);
        chk("t6_we_before_rst", {31'b0, bus.dmem_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_we_dropped", {31'b0, bus.dmem_we}, 32'd0);
        chk("t6_pc_reset", 32'(pc_out), 32'h0);
        chk("t6_x1_cleared", dut.rf_reg[1], 32'd0);
        chk("t6_x2_cleared", dut.rf_reg[2], 32'd0);
        chk("t6_instret_cleared", 32'(instret), 32'd0);
        repeat (2) @(posedge clk);
        chk("t6_ram_untouched", ram[2], 32'd0);
        ready_delay = 0;

        // ---- Test 7: pc wrap with PC_W=8 ----
        clear_mem();
        rom[0]  = enc_j(12'h0FC, 0);           // jal x0,+0xFC
        rom[63] = enc_b(8, 0, 0, 3'b000);      // 0xFC beq x0,x0,+8
        do_reset();
        run_instr(lat);
        chk("t7_pc_fc", 32'(pc_out), 32'hFC);
        run_instr(lat);
        chk("t7_wrap_lat", lat, 32'd3);
        chk("t7_wrap_pc", 32'(pc_out), 32'h04);
        repeat (3) @(negedge clk);
        chk("t7_halted", {31'b0, halted}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
